// File: rtl/dense_rom_pkg.sv
// Shared constants and state encoding for the dense-layer ROM read sequencer.
// Widths match the 128 x 16-bit weight/bias ROMs.
package dense_rom_pkg;

   localparam int DENSE_DEPTH  = 128;
   localparam int DENSE_ADDR_W = 7;
   localparam int DENSE_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } stream_state_t;

endpackage

// File: rtl/dense_skid_fifo2.sv
// Two-entry FIFO that absorbs the one-cycle ROM latency under backpressure.
// Slot 0 is always the head; push and pop in the same cycle are allowed when full.
module dense_skid_fifo2 #(
   parameter int WIDTH = 23
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_entry,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] slot0_reg;
   logic [WIDTH-1:0] slot1_reg;
   logic [1:0]       count_reg;
   logic             pop_eff;

   assign pop_eff = pop && (count_reg != 2'd0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slot0_reg <= '0;
         slot1_reg <= '0;
         count_reg <= 2'd0;
      end else begin
         case ({push, pop_eff})
            2'b10: begin
               if (count_reg == 2'd0) begin
                  slot0_reg <= push_entry;
                  count_reg <= 2'd1;
               end else if (count_reg == 2'd1) begin
                  slot1_reg <= push_entry;
                  count_reg <= 2'd2;
               end
            end
            2'b01: begin
               slot0_reg <= slot1_reg;
               count_reg <= count_reg - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; the new entry lands behind whatever remains.
               if (count_reg == 2'd1) begin
                  slot0_reg <= push_entry;
               end else begin
                  slot0_reg <= slot1_reg;
                  slot1_reg <= push_entry;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign head  = slot0_reg;
   assign count = count_reg;
   assign empty = (count_reg == 2'd0);
   assign full  = (count_reg == 2'd2);

endmodule

// File: rtl/dense_rom_streamer.sv
// Walks a dense ROM from address 0 on start and presents its words as a
// valid/ready stream with index and last markers, one word per cycle.
module dense_rom_streamer
   import dense_rom_pkg::*;
#(
   parameter int DEPTH  = DENSE_DEPTH,
   parameter int ADDR_W = DENSE_ADDR_W,
   parameter int DATA_W = DENSE_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   cfg_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_last
);

   localparam int ENTRY_W = ADDR_W + DATA_W;

   stream_state_t     state_reg;
   logic              busy_reg;
   logic              done_reg;
   logic [ADDR_W-1:0] rom_addr_reg;
   logic [ADDR_W-1:0] issue_cnt_reg;
   logic [ADDR_W-1:0] out_cnt_reg;
   logic [ADDR_W-1:0] last_reg;
   logic              inflight_reg;
   logic [ADDR_W-1:0] inflight_idx_reg;

   logic [ADDR_W-1:0]  cfg_last;
   logic [2:0]         occupancy;
   logic               issue;
   logic               pop;
   logic               accept;
   logic               final_pop;
   logic [ENTRY_W-1:0] fifo_head;
   logic [1:0]         fifo_count;
   logic               fifo_empty;
   logic               fifo_full;

   // A zero or oversized count means the whole ROM.
   always_comb begin
      if ((cfg_count == '0) || (cfg_count > (ADDR_W + 1)'(DEPTH))) begin
         cfg_last = ADDR_W'(DEPTH - 1);
      end else begin
         cfg_last = ADDR_W'(cfg_count - 1'b1);
      end
   end

   assign pop       = out_valid && out_ready;
   assign occupancy = 3'(fifo_count) + 3'(inflight_reg) - 3'(pop);
   assign issue     = (state_reg == RUN) && (occupancy < 3'd2);
   assign accept    = (state_reg == IDLE) && start && !done_reg;
   assign final_pop = pop && (state_reg == DRAIN) && (out_cnt_reg == last_reg);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg        <= IDLE;
         busy_reg         <= 1'b0;
         done_reg         <= 1'b0;
         rom_addr_reg     <= '0;
         issue_cnt_reg    <= '0;
         out_cnt_reg      <= '0;
         last_reg         <= '0;
         inflight_reg     <= 1'b0;
         inflight_idx_reg <= '0;
      end else begin
         done_reg     <= 1'b0;
         inflight_reg <= issue;
         if (issue) begin
            inflight_idx_reg <= rom_addr_reg;
         end
         if (pop) begin
            out_cnt_reg <= out_cnt_reg + 1'b1;
         end
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  state_reg     <= RUN;
                  busy_reg      <= 1'b1;
                  rom_addr_reg  <= '0;
                  issue_cnt_reg <= '0;
                  out_cnt_reg   <= '0;
                  last_reg      <= cfg_last;
               end
            end
            RUN: begin
               if (issue) begin
                  issue_cnt_reg <= issue_cnt_reg + 1'b1;
                  // The final address stays on the bus once issued.
                  if (issue_cnt_reg == last_reg) begin
                     state_reg <= DRAIN;
                  end else begin
                     rom_addr_reg <= rom_addr_reg + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (final_pop) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   dense_skid_fifo2 #(
      .WIDTH(ENTRY_W)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (inflight_reg),
      .push_entry ({inflight_idx_reg, rom_data}),
      .pop        (pop),
      .head       (fifo_head),
      .count      (fifo_count),
      .empty      (fifo_empty),
      .full       (fifo_full)
   );

   // The issue rule guarantees a full FIFO is never pushed without a pop.
   always @(posedge clock) begin
      if (!reset) begin
         assert (!(fifo_full && inflight_reg && !pop));
      end
   end

   assign busy      = busy_reg;
   assign done      = done_reg;
   assign rom_addr  = rom_addr_reg;
   assign out_valid = !fifo_empty;
   assign out_data  = fifo_head[DATA_W-1:0];
   assign out_index = fifo_head[ENTRY_W-1:DATA_W];
   assign out_last  = out_valid && (out_index == last_reg);

endmodule

// File: tb/tb_dense_rom_streamer.sv
// Directed bench for dense_rom_streamer against a registered-read ROM model;
// cycle numbers are counted from the cycle in which start is sampled.
module tb_dense_rom_streamer;
   import dense_rom_pkg::*;

   localparam int ADDR_W = DENSE_ADDR_W;
   localparam int DATA_W = DENSE_DATA_W;
   localparam int DEPTH  = DENSE_DEPTH;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W:0]   cfg_count = '0;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_index;
   logic              out_last;

   int n_cmp = 0;
   int n_err = 0;

   logic [DATA_W-1:0] rom [DEPTH];

   dense_rom_streamer #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .cfg_count (cfg_count),
      .busy      (busy),
      .done      (done),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last)
   );

   always #5 clock = ~clock;

   always @(posedge clock) rom_data <= rom[rom_addr];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_outputs();
      return 64'({busy, done, rom_addr, out_valid, out_data, out_index, out_last});
   endfunction

   // One stream from start to done; exp_done < 0 skips the done-cycle check.
   task automatic run_stream(input string name, input int cfg, input int n, input bit bp,
                             input int busy_start_at, input bit start_on_done,
                             input int abort_after, input int exp_done);
      int k = 0;
      int cyc = 1;
      int first_cyc = -1;
      bit stalled = 1'b0;
      bit finished = 1'b0;
      logic [DATA_W-1:0] hold_data = '0;
      logic [ADDR_W-1:0] hold_idx = '0;
      logic hold_last = 1'b0;
      start = 1'b1;
      cfg_count = (ADDR_W + 1)'(cfg);
      tick();
      start = 1'b0;
      cfg_count = (ADDR_W + 1)'(5);
      chk({name, "_busy_s1"}, busy, 1);
      chk({name, "_addr_s1"}, rom_addr, 0);
      while (!finished && cyc < 2000) begin
         out_ready = bp ? ((cyc - 1) % 4 == 0 || (cyc - 1) % 4 == 3) : 1'b1;
         if (cyc == busy_start_at) begin
            start = 1'b1;
            cfg_count = (ADDR_W + 1)'(3);
         end else begin
            start = 1'b0;
         end
         chk({name, "_busy_run"}, busy, 1);
         chk({name, "_no_early_done"}, done, 0);
         if (stalled) begin
            chk({name, "_stall_valid"}, out_valid, 1);
            chk({name, "_stall_data"}, out_data, hold_data);
            chk({name, "_stall_index"}, out_index, hold_idx);
            chk({name, "_stall_last"}, out_last, hold_last);
         end
         stalled = 1'b0;
         if (out_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (out_ready) begin
               chk({name, "_data"}, out_data, rom[k]);
               chk({name, "_index"}, out_index, k);
               chk({name, "_last"}, out_last, (k == n - 1));
               k++;
               if (k == n) finished = 1'b1;
            end else begin
               stalled = 1'b1;
               hold_data = out_data;
               hold_idx = out_index;
               hold_last = out_last;
            end
         end
         if (abort_after > 0 && k == abort_after) begin
            #2 reset = 1'b1;
            #1 chk({name, "_async_clear"}, all_outputs(), 0);
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
               tick();
               chk({name, "_held_in_reset"}, all_outputs(), 0);
            end
            reset = 1'b0;
            tick();
            chk({name, "_after_reset"}, all_outputs(), 0);
            $display("stream %s: aborted after %0d words", name, k);
            return;
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      chk({name, "_word_count"}, k, n);
      chk({name, "_first_valid_cycle"}, first_cyc, 3);
      chk({name, "_done_pulse"}, done, 1);
      chk({name, "_busy_cleared"}, busy, 0);
      chk({name, "_valid_cleared"}, out_valid, 0);
      if (exp_done >= 0) chk({name, "_done_cycle"}, cyc, exp_done);
      $display("stream %s: %0d words, done at s+%0d", name, k, cyc);
      if (start_on_done) begin
         start = 1'b1;
         cfg_count = (ADDR_W + 1)'(2);
         tick();
         start = 1'b0;
         chk({name, "_start_on_done_busy"}, busy, 0);
         chk({name, "_start_on_done_done"}, done, 0);
      end else begin
         tick();
         chk({name, "_done_one_cycle"}, done, 0);
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) rom[i] = 16'((i * 16'h0351) ^ 16'hA5C3);
      rom[0]   = 16'h0110;
      rom[1]   = 16'hFD90;
      rom[127] = 16'h06E0;

      tick();
      tick();
      chk("reset_outputs", all_outputs(), 0);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_outputs", all_outputs(), 0);
      end
      $display("idle: 20 cycles without start");

      run_stream("full", 0, 128, 1'b0, -1, 1'b0, 0, 131);
      tick();
      run_stream("backpressure", 8, 8, 1'b1, -1, 1'b0, 0, -1);
      tick();
      run_stream("count1", 1, 1, 1'b0, -1, 1'b0, 0, 4);
      tick();
      run_stream("count200", 200, 128, 1'b0, -1, 1'b0, 0, 131);
      tick();
      run_stream("busy_start", 16, 16, 1'b0, 10, 1'b1, 0, 19);
      run_stream("restart", 3, 3, 1'b0, -1, 1'b0, 0, 6);
      tick();
      run_stream("abort", 0, 128, 1'b0, -1, 1'b0, 40, -1);
      run_stream("after_abort", 4, 4, 1'b0, -1, 1'b0, 0, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
